// File: rtl/comparator_serial64.sv
// comparator_serial64
//   Multi-cycle magnitude comparator. Takes one operand pair over a
//   valid/ready handshake, scans it MSB-first DIGIT bits per cycle and stops
//   at the first digit that differs. It returns EQ, signed LT and unsigned LTu,
//   with the same meaning as the parallel comparator tree.
//
// Parameters
//   WIDTH  operand width, a multiple of DIGIT
//   DIGIT  bits examined per RUN cycle, a power of two in 1..WIDTH
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   in_valid   A/B pair valid
//   in_ready   pair can be accepted (high only in IDLE)
//   A, B       operands (two's complement for LT)
//   out_valid  EQ/LT/LTu valid (DONE state)
//   out_ready  consumer accepts the result
//   EQ         A == B
//   LT         A < B, signed
//   LTu        A < B, unsigned
//   busy       block is not IDLE
module comparator_serial64 #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             EQ,
  output logic             LT,
  output logic             LTu,
  output logic             busy
);

  localparam int ND = WIDTH / DIGIT;
  localparam int PW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [PW-1:0] PTR_TOP = PW'(ND - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [WIDTH-1:0] a_q, b_q;
  logic [PW-1:0]    ptr;
  logic             sdiff;   // operand sign bits differ
  logic             sa;      // sign bit of A
  logic [DIGIT-1:0] a_dig, b_dig;
  logic             dig_ne;
  logic             dig_lt;
  logic             last;

  // Digit under examination; ptr counts down from the top digit.
  assign a_dig  = a_q[int'(ptr)*DIGIT +: DIGIT];
  assign b_dig  = b_q[int'(ptr)*DIGIT +: DIGIT];
  assign dig_ne = (a_dig != b_dig);
  assign dig_lt = (a_dig < b_dig);
  assign last   = (ptr == '0);

  // Handshake outputs depend on state only, so no input reaches an output
  // combinationally.
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid)       state_n = RUN;
      RUN:     if (dig_ne || last) state_n = DONE;
      DONE:    if (out_ready)      state_n = IDLE;
      default:                     state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      ptr   <= PTR_TOP;
      sdiff <= 1'b0;
      sa    <= 1'b0;
      EQ    <= 1'b0;
      LT    <= 1'b0;
      LTu   <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= A;
            b_q   <= B;
            ptr   <= PTR_TOP;
            sdiff <= A[WIDTH-1] ^ B[WIDTH-1];
            sa    <= A[WIDTH-1];
          end
        end
        RUN: begin
          if (dig_ne) begin
            // First differing digit decides the unsigned order. When the
            // signs differ, the negative operand (sign bit 1) is the smaller.
            EQ  <= 1'b0;
            LTu <= dig_lt;
            LT  <= sdiff ? sa : dig_lt;
          end else if (last) begin
            EQ  <= 1'b1;
            LTu <= 1'b0;
            LT  <= 1'b0;
          end else begin
            ptr <= ptr - PW'(1);
          end
        end
        default: ;  // DONE: flags held until the result handshake
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_serial64.sv
// Bench for comparator_serial64: three instances (DIGIT = 1, 2, 8) share a
// clock. Directed cases run on the DIGIT=2 instance, random pairs on all
// three in parallel. Drivers push the expected result (flags plus latency in
// edges counted from the accept edge inclusive) into a per-instance queue;
// one monitor pops on every rising out_valid and checks held flags while
// the result waits for out_ready.
module tb_comparator_serial64;

  typedef struct {
    logic eq;
    logic lt;
    logic ltu;
    int   lat;
    int   acc;
  } exp_t;

  localparam int NI = 3;
  localparam int NRAND = 3400;
  int dig_of [NI] = '{1, 2, 8};

  logic        clk = 1'b0;
  int          cyc = 0;
  logic        rst       [NI];
  logic        in_valid  [NI];
  logic        in_ready  [NI];
  logic [63:0] a         [NI];
  logic [63:0] b         [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic        eq        [NI];
  logic        lt        [NI];
  logic        ltu       [NI];
  logic        busy      [NI];
  logic        rnd_or    [NI];

  exp_t sb [NI][$];
  exp_t cur [NI];
  logic pv [NI];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : 8;
    comparator_serial64 #(.WIDTH(64), .DIGIT(D)) u_dut (
      .clk(clk), .reset(rst[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .A(a[g]), .B(b[g]), .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .EQ(eq[g]), .LT(lt[g]), .LTu(ltu[g]), .busy(busy[g]));
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain comparisons; latency from the highest differing bit.
  function automatic exp_t model(input logic [63:0] x, input logic [63:0] y, input int d);
    exp_t e;
    int   msb;
    logic [63:0] diff;
    e.eq  = (x == y);
    e.lt  = ($signed(x) < $signed(y));
    e.ltu = (x < y);
    e.acc = 0;
    diff  = x ^ y;
    msb   = -1;
    for (int j = 63; j >= 0; j--) begin
      if (diff[j]) begin
        msb = j;
        break;
      end
    end
    e.lat = (msb < 0) ? (64 / d + 1) : ((63 - msb) / d + 2);
    return e;
  endfunction

  task automatic send(input int i, input logic [63:0] x, input logic [63:0] y, input bit track);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk);
    in_valid[i] = 1'b1;
    a[i] = x;
    b[i] = y;
    while (!in_ready[i] && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready[i]) begin
      failures++;
      $display("FAIL accept_timeout inst=%0d", i);
      in_valid[i] = 1'b0;
      return;
    end
    e = model(x, y, dig_of[i]);
    e.acc = cyc;
    if (track) sb[i].push_back(e);
    @(posedge clk);
    #1 in_valid[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    int w;
    w = 0;
    while ((sb[i].size() != 0 || busy[i]) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("drain_pending_%0d", i), 64'(sb[i].size()), 64'd0);
  endtask

  task automatic rand_run(input int i, input int n);
    logic [63:0] x, y;
    int r;
    logic [63:0] edges [4];
    edges = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    rnd_or[i] = 1'b1;
    for (int k = 0; k < n; k++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      r = $urandom_range(0, 31);
      if (r == 0) y = x;
      else if (r <= 4) y = x ^ (64'd1 << $urandom_range(0, 63));
      else if (r <= 7) begin
        x = edges[$urandom_range(0, 3)];
        y = edges[$urandom_range(0, 3)];
      end
      send(i, x, y, 1'b1);
    end
    drain(i);
    rnd_or[i] = 1'b0;
    out_ready[i] = 1'b1;
  endtask

  // Random backpressure on instances in random mode.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++)
        if (rnd_or[i]) out_ready[i] = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pop on each rising out_valid, then check the flags stay put.
  initial begin
    for (int i = 0; i < NI; i++) pv[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (out_valid[i]) begin
          if (!pv[i]) begin
            if (sb[i].size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_result inst=%0d EQ=%0b LT=%0b LTu=%0b", i, eq[i], lt[i], ltu[i]);
            end else begin
              cur[i] = sb[i].pop_front();
              chk($sformatf("EQ_%0d", i), 64'(eq[i]), 64'(cur[i].eq));
              chk($sformatf("LT_%0d", i), 64'(lt[i]), 64'(cur[i].lt));
              chk($sformatf("LTu_%0d", i), 64'(ltu[i]), 64'(cur[i].ltu));
              chk($sformatf("latency_%0d", i), 64'(cyc - cur[i].acc), 64'(cur[i].lat));
            end
          end else begin
            chk($sformatf("hold_flags_%0d", i), {61'd0, eq[i], lt[i], ltu[i]},
                {61'd0, cur[i].eq, cur[i].lt, cur[i].ltu});
          end
          chk($sformatf("in_ready_in_done_%0d", i), 64'(in_ready[i]), 64'd0);
        end
        pv[i] = out_valid[i];
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; in_valid[i] = 1'b0; a[i] = '0; b[i] = '0;
      out_ready[i] = 1'b1; rnd_or[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk($sformatf("reset_outs_%0d", i),
          {58'd0, in_ready[i], out_valid[i], eq[i], lt[i], ltu[i], busy[i]}, 64'b100000);

    // Directed cases on the DIGIT=2 instance.
    send(1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1); drain(1);
    send(1, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b1); drain(1);
    send(1, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0003, 1'b1); drain(1);
    send(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1); drain(1);
    send(1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1); drain(1);

    // Backpressure: result held 10 cycles, in_valid pulses ignored.
    out_ready[1] = 1'b0;
    send(1, 64'h4000_0000_0000_0000, 64'h0, 1'b1);
    for (int w = 0; w < 100 && !out_valid[1]; w++) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      in_valid[1] = k[0];
      a[1] = 64'h5;
      b[1] = 64'h6;
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid[1]), 64'd1);
    end
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b1;
    @(negedge clk);
    chk("bp_release_idle", {62'd0, in_ready[1], out_valid[1]}, 64'b10);
    send(1, 64'h10, 64'h10, 1'b1); drain(1);

    // Reset in RUN cycle 5 of an equal scan: no result, outputs cleared.
    send(1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0);
    repeat (5) @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    chk("mid_run_reset", {58'd0, in_ready[1], out_valid[1], eq[1], lt[1], ltu[1], busy[1]}, 64'b100000);
    repeat (40) @(negedge clk);
    chk("no_result_after_abort", 64'(out_valid[1]), 64'd0);

    // Reset and in_valid together: pair dropped.
    rst[1] = 1'b1; in_valid[1] = 1'b1; a[1] = 64'h1; b[1] = 64'h2;
    @(negedge clk);
    rst[1] = 1'b0; in_valid[1] = 1'b0;
    chk("reset_wins_busy", 64'(busy[1]), 64'd0);
    send(1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1); drain(1);
    repeat (5) @(negedge clk);
    chk("no_stray_result", 64'(out_valid[1]), 64'd0);

    fork
      rand_run(0, NRAND);
      rand_run(1, NRAND);
      rand_run(2, NRAND);
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
